// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer generators (write-side
// wptr_full_gen and the read-side rptr_empty_gen).
//   FIFO_ADDR_SIZE : default RAM address width (depth = 2**FIFO_ADDR_SIZE)
//   ptr_t          : pointer type at the default width (ADDR_SIZE+1 bits; the
//                    extra MSB tells "same lap" from "one lap ahead")
//   bin2gray       : binary -> reflected Gray code
//   gray2bin       : reflected Gray code -> binary
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 4;

  typedef logic [FIFO_ADDR_SIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[FIFO_ADDR_SIZE] = gray[FIFO_ADDR_SIZE];
    for (int i = FIFO_ADDR_SIZE - 1; i >= 0; i--) begin
      bin[i] = bin[i + 1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Purely combinational Gray-to-binary converter of parameterized width.
//   i_gray [WIDTH-1:0] : Gray-coded input
//   o_bin  [WIDTH-1:0] : binary equivalent
// Bit i of the result is the XOR-reduction of every Gray bit from i upward.
// -----------------------------------------------------------------------------
module gray2bin_conv #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^(i_gray >> i);
  end

endmodule

// File: rtl/wptr_full_gen.sv
// -----------------------------------------------------------------------------
// wptr_full_gen
// Write-domain pointer and flag generator for the asynchronous FIFO.
//   clk            : write-domain clock
//   rst            : synchronous active-high reset (dominates all inputs)
//   i_winc         : write request
//   i_wq2_rptr     : Gray read pointer, already synchronized into clk domain
//   i_clr_ovf      : clears o_overflow (a simultaneous new overflow wins)
//   o_waddr        : RAM write address (low bits of the binary write pointer)
//   o_wptr         : registered Gray write pointer, feeds the CDC synchronizer
//   o_wen          : RAM write enable = i_winc && !o_wfull
//   o_wfull        : FIFO full, registered
//   o_walmost_full : fill level >= AFULL_THRESH, registered
//   o_wlevel       : fill level as seen by the writer, registered
//   o_overflow     : sticky flag, a write was attempted while full
//
// Handshake: i_winc is a request and !o_wfull is its ready. A write transfers
// (o_wen=1, pointer advances) only in a cycle where both hold; a request while
// full is dropped, never held pending, and it sets o_overflow.
// -----------------------------------------------------------------------------
module wptr_full_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE    = FIFO_ADDR_SIZE,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_winc,
  input  logic [ADDR_SIZE:0]   i_wq2_rptr,
  input  logic                 i_clr_ovf,
  output logic [ADDR_SIZE-1:0] o_waddr,
  output logic [ADDR_SIZE:0]   o_wptr,
  output logic                 o_wen,
  output logic                 o_wfull,
  output logic                 o_walmost_full,
  output logic [ADDR_SIZE:0]   o_wlevel,
  output logic                 o_overflow
);

  localparam logic [ADDR_SIZE:0] AFULL_LVL = (ADDR_SIZE + 1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] r_wbin;
  logic [ADDR_SIZE:0] r_wptr;
  logic               r_wfull;
  logic               r_walmost_full;
  logic [ADDR_SIZE:0] r_wlevel;
  logic               r_overflow;

  logic               w_accept;
  logic [ADDR_SIZE:0] w_wbin_next;
  logic [ADDR_SIZE:0] w_wgray_next;
  logic [ADDR_SIZE:0] w_full_match;
  logic [ADDR_SIZE:0] w_rbin;
  logic [ADDR_SIZE:0] w_level_next;
  logic               w_full_next;

  gray2bin_conv #(
    .WIDTH (ADDR_SIZE + 1)
  ) u_rptr_g2b (
    .i_gray (i_wq2_rptr),
    .o_bin  (w_rbin)
  );

  assign w_accept     = i_winc && !r_wfull;
  assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_accept};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Writer is exactly one lap ahead of the reader: in Gray code that means the
  // top two bits are inverted and the remaining bits are equal.
  assign w_full_match = {~i_wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], i_wq2_rptr[ADDR_SIZE-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_match);

  // Modular subtraction gives the occupancy even across pointer wrap.
  assign w_level_next = w_wbin_next - w_rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= w_full_next;
      r_walmost_full <= (w_level_next >= AFULL_LVL);
      r_wlevel       <= w_level_next;
      // Set has priority so an overflow in the clearing cycle is not lost.
      if (i_winc && r_wfull) begin
        r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // o_waddr is the pre-increment address: it addresses the write happening now.
  assign o_waddr        = r_wbin[ADDR_SIZE-1:0];
  assign o_wptr         = r_wptr;
  assign o_wen          = w_accept;
  assign o_wfull        = r_wfull;
  assign o_walmost_full = r_walmost_full;
  assign o_wlevel       = r_wlevel;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_wptr_full_gen.sv
module tb_wptr_full_gen;

  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int THR   = 12;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            i_winc;
  logic [AS:0]     i_wq2_rptr;
  logic            i_clr_ovf;
  logic [AS-1:0]   o_waddr;
  logic [AS:0]     o_wptr;
  logic            o_wen;
  logic            o_wfull;
  logic            o_walmost_full;
  logic [AS:0]     o_wlevel;
  logic            o_overflow;

  always #5 clk = ~clk;

  wptr_full_gen #(
    .ADDR_SIZE    (AS),
    .AFULL_THRESH (THR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_winc         (i_winc),
    .i_wq2_rptr     (i_wq2_rptr),
    .i_clr_ovf      (i_clr_ovf),
    .o_waddr        (o_waddr),
    .o_wptr         (o_wptr),
    .o_wen          (o_wen),
    .o_wfull        (o_wfull),
    .o_walmost_full (o_walmost_full),
    .o_wlevel       (o_wlevel),
    .o_overflow     (o_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  // Writer tracked as a count of accepted writes (mod 2*DEPTH), reader as a
  // plain binary count; occupancy is their difference.
  int   m_wbin  = 0;
  int   m_rb    = 0;
  int   m_level = 0;
  logic m_full  = 1'b0;
  logic m_af    = 1'b0;
  logic m_ovf   = 1'b0;
  logic m_winc, m_clr, m_rst;

  function automatic logic [AS:0] to_gray(input int n);
    int v;
    v = n % PMOD;
    return 5'(v ^ (v / 2));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic winc, input logic clr, input logic rs, input int rb);
    m_winc = winc; m_clr = clr; m_rst = rs; m_rb = rb % PMOD;
    i_winc = winc; i_clr_ovf = clr; rst = rs; i_wq2_rptr = to_gray(m_rb);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_rst) begin
      m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (m_winc && m_full) m_ovf = 1'b1;
      else if (m_clr) m_ovf = 1'b0;
      if (m_winc && !m_full) m_wbin = (m_wbin + 1) % PMOD;
      m_level = (m_wbin - m_rb + PMOD) % PMOD;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= THR);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b1, 0); tick();
    apply(1'b1, 1'b0, 1'b1, 0); tick();
    apply(1'b0, 1'b0, 1'b0, 0);
    n_checks++; if (o_wptr !== 5'd0) begin n_errors++; $display("FAIL reset_wptr got=%b exp=00000", o_wptr); end
    n_checks++; if (o_waddr !== 4'd0) begin n_errors++; $display("FAIL reset_waddr got=%0d exp=0", o_waddr); end
    n_checks++; if (o_wfull !== 1'b0 || o_walmost_full !== 1'b0) begin n_errors++; $display("FAIL reset_flags got full=%b af=%b exp=0,0", o_wfull, o_walmost_full); end
    n_checks++; if (o_wlevel !== 5'd0) begin n_errors++; $display("FAIL reset_level got=%0d exp=0", o_wlevel); end
    n_checks++; if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got=%b exp=0", o_overflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0);
      n_checks++; if (o_waddr !== 4'(i)) begin n_errors++; $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, o_waddr, i); end
      n_checks++; if (o_wen !== 1'b1) begin n_errors++; $display("FAIL fill_wen[%0d] got=%b exp=1", i, o_wen); end
      tick();
      n_checks++; if (o_walmost_full !== (i + 1 >= THR)) begin n_errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, o_walmost_full, (i + 1 >= THR)); end
      n_checks++; if (o_wfull !== (i == DEPTH - 1)) begin n_errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, o_wfull, (i == DEPTH - 1)); end
      n_checks++; if (o_wlevel !== 5'(i + 1)) begin n_errors++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, o_wlevel, i + 1); end
      n_checks++; if (o_wptr !== to_gray(i + 1)) begin n_errors++; $display("FAIL fill_wptr[%0d] got=%b exp=%b", i, o_wptr, to_gray(i + 1)); end
    end
    n_checks++; if (o_wptr !== 5'b11000) begin n_errors++; $display("FAIL fill_wptr_final got=%b exp=11000", o_wptr); end
  endtask

  task automatic test_overflow();
    apply(1'b1, 1'b0, 1'b0, 0);
    n_checks++; if (o_wen !== 1'b0) begin n_errors++; $display("FAIL ovf_wen got=%b exp=0", o_wen); end
    tick();
    n_checks++; if (o_wptr !== 5'b11000) begin n_errors++; $display("FAIL ovf_wptr_hold got=%b exp=11000", o_wptr); end
    n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set got=%b exp=1", o_overflow); end
    apply(1'b0, 1'b1, 1'b0, 0); tick();
    n_checks++; if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got=%b exp=0", o_overflow); end
    apply(1'b1, 1'b1, 1'b0, 0); tick();
    n_checks++; if (o_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins got=%b exp=1", o_overflow); end
    n_checks++; if (o_wlevel !== 5'd16 || o_wfull !== 1'b1) begin n_errors++; $display("FAIL ovf_level got=%0d full=%b exp=16,1", o_wlevel, o_wfull); end
  endtask

  task automatic test_release();
    apply(1'b0, 1'b1, 1'b0, 1); tick();
    n_checks++; if (o_wfull !== 1'b0) begin n_errors++; $display("FAIL rel_full got=%b exp=0", o_wfull); end
    n_checks++; if (o_wlevel !== 5'd15) begin n_errors++; $display("FAIL rel_level got=%0d exp=15", o_wlevel); end
    n_checks++; if (o_overflow !== 1'b0) begin n_errors++; $display("FAIL rel_ovf got=%b exp=0", o_overflow); end
    apply(1'b1, 1'b0, 1'b0, 1);
    n_checks++; if (o_waddr !== 4'd0 || o_wen !== 1'b1) begin n_errors++; $display("FAIL rel_write got addr=%0d wen=%b exp=0,1", o_waddr, o_wen); end
    tick();
    n_checks++; if (o_wfull !== 1'b1 || o_wptr !== 5'b11001) begin n_errors++; $display("FAIL rel_refill got full=%b wptr=%b exp=1,11001", o_wfull, o_wptr); end
  endtask

  // Writes until the pointer has gone all the way round; the reader trails at
  // a random distance so the FIFO never fills.
  task automatic test_wrap();
    logic [AS:0] prev;
    int rb;
    int budget;
    apply(1'b0, 1'b0, 1'b1, 0); tick();
    rb = 0;
    budget = 0;
    while (m_wbin != PMOD - 1 && budget < 200) begin
      if ((m_wbin - rb + PMOD) % PMOD > $urandom_range(2, 10)) rb = (rb + 1) % PMOD;
      prev = o_wptr;
      apply(1'b1, 1'($urandom_range(0, 1)), 1'b0, rb);
      n_checks++; if (o_wen !== 1'b1) begin n_errors++; $display("FAIL wrap_wen wbin=%0d got=%b exp=1", m_wbin, o_wen); end
      tick();
      n_checks++; if (o_wptr !== to_gray(m_wbin) || $countones(o_wptr ^ prev) != 1) begin n_errors++; $display("FAIL wrap_wptr wbin=%0d got=%b exp=%b prev=%b", m_wbin, o_wptr, to_gray(m_wbin), prev); end
      n_checks++; if (o_wlevel !== 5'(m_level) || o_walmost_full !== m_af || o_wfull !== m_full) begin n_errors++; $display("FAIL wrap_flags wbin=%0d got lvl=%0d af=%b full=%b exp %0d,%b,%b", m_wbin, o_wlevel, o_walmost_full, o_wfull, m_level, m_af, m_full); end
      budget++;
    end
    n_checks++; if (budget >= 200) begin n_errors++; $display("FAIL wrap_budget got=%0d exp<200", budget); end
    n_checks++; if (o_wptr !== 5'b10000) begin n_errors++; $display("FAIL wrap_wptr31 got=%b exp=10000", o_wptr); end
    n_checks++; if (o_waddr !== 4'd15) begin n_errors++; $display("FAIL wrap_waddr31 got=%0d exp=15", o_waddr); end
    rb = (rb + 1) % PMOD;
    apply(1'b1, 1'b0, 1'b0, rb); tick();
    n_checks++; if (o_wptr !== 5'b00000) begin n_errors++; $display("FAIL wrap_wptr0 got=%b exp=00000", o_wptr); end
    n_checks++; if (o_waddr !== 4'd0) begin n_errors++; $display("FAIL wrap_waddr0 got=%0d exp=0", o_waddr); end
    n_checks++; if (o_wlevel !== 5'(m_level)) begin n_errors++; $display("FAIL wrap_level0 got=%0d exp=%0d", o_wlevel, m_level); end
  endtask

  task automatic test_mid_reset();
    apply(1'b0, 1'b0, 1'b1, 0); tick();
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b0, 1'b0, 0); tick();
    end
    n_checks++; if (o_waddr !== 4'd7 || o_wptr !== to_gray(7)) begin n_errors++; $display("FAIL mid_pre got addr=%0d wptr=%b exp=7,%b", o_waddr, o_wptr, to_gray(7)); end
    apply(1'b1, 1'b0, 1'b1, 0); tick();
    n_checks++; if (o_wptr !== 5'd0 || o_wlevel !== 5'd0) begin n_errors++; $display("FAIL mid_ptr got wptr=%b lvl=%0d exp=0,0", o_wptr, o_wlevel); end
    n_checks++; if (o_wfull !== 1'b0 || o_overflow !== 1'b0 || o_waddr !== 4'd0) begin n_errors++; $display("FAIL mid_flags got full=%b ovf=%b addr=%0d exp=0,0,0", o_wfull, o_overflow, o_waddr); end
  endtask

  // Random traffic: reader advances randomly but never passes the writer.
  task automatic test_random();
    int rb;
    logic w;
    logic c;
    rb = m_wbin;
    for (int i = 0; i < 300; i++) begin
      if ((m_wbin - rb + PMOD) % PMOD > 0 && $urandom_range(0, 2) == 0) rb = (rb + 1) % PMOD;
      w = 1'($urandom_range(0, 3) != 0);
      c = 1'($urandom_range(0, 7) == 0);
      apply(w, c, 1'($urandom_range(0, 99) == 0), rb);
      if (m_rst) rb = 0;
      if (m_rst) i_wq2_rptr = 5'd0;
      if (m_rst) m_rb = 0;
      #0;
      n_checks++; if (o_wen !== (m_rst ? o_wen : (w && !m_full)) || o_waddr !== 4'(m_wbin)) begin n_errors++; $display("FAIL rand_comb[%0d] got wen=%b addr=%0d exp %b,%0d", i, o_wen, o_waddr, w && !m_full, m_wbin % DEPTH); end
      tick();
      n_checks++; if (o_wptr !== to_gray(m_wbin) || o_wlevel !== 5'(m_level)) begin n_errors++; $display("FAIL rand_ptr[%0d] got wptr=%b lvl=%0d exp %b,%0d", i, o_wptr, o_wlevel, to_gray(m_wbin), m_level); end
      n_checks++; if (o_wfull !== m_full || o_walmost_full !== m_af || o_overflow !== m_ovf) begin n_errors++; $display("FAIL rand_flags[%0d] got full=%b af=%b ovf=%b exp %b,%b,%b", i, o_wfull, o_walmost_full, o_overflow, m_full, m_af, m_ovf); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; i_winc = 1'b0; i_clr_ovf = 1'b0; i_wq2_rptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wptr_full_gen.md
Name: wptr_full_gen

Overview:
Write-side pointer and flag generator for the asynchronous FIFO, running in the write clock domain.
- Accepts write requests and produces the binary RAM write address.
- Produces the registered Gray-coded write pointer. This pointer is sent to the read domain through the 2-FF pointer synchronizer.
- Uses the read pointer already synchronized into this domain to compute full, almost-full, fill level and a sticky overflow error.

Parameters:
- ADDR_SIZE, 4, RAM address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits; legal range ADDR_SIZE >= 2.
- AFULL_THRESH, 12, fill level at or above which o_walmost_full asserts; legal range 1..2**ADDR_SIZE.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  synchronous, active-high reset.
- i_winc  input  1  write request.
- i_wq2_rptr  input  ADDR_SIZE+1  Gray read pointer, already synchronized into clk domain.
- i_clr_ovf  input  1  clears o_overflow.
- o_waddr  output  ADDR_SIZE  RAM write address = low ADDR_SIZE bits of binary write pointer.
- o_wptr  output  ADDR_SIZE+1  registered Gray write pointer, to the synchronizer.
- o_wen  output  1  RAM write enable = i_winc && !o_wfull (combinational qualify).
- o_wfull  output  1  FIFO full, registered.
- o_walmost_full  output  1  level >= AFULL_THRESH, registered.
- o_wlevel  output  ADDR_SIZE+1  fill level as seen by writer, registered, 0..2**ADDR_SIZE.
- o_overflow  output  1  sticky: write attempted while full.

Behaviour:
- Reset (rst=1 at posedge clk): wbin=0, o_wptr=0, o_wfull=0, o_walmost_full=0, o_wlevel=0, o_overflow=0. Reset dominates all other inputs.
- Mid-operation reset returns the pointers to 0 on the next edge. The system resets the read side in the same window; this block does not check that.
- accept = i_winc && !o_wfull. A write while full is dropped: no pointer change, RAM not written.
- Next-state computation:
  - wbin_next = wbin + accept, modulo 2**(ADDR_SIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Registered updates each cycle: wbin <= wbin_next; o_wptr <= wgray_next.
- o_wptr comes straight from a flop; no combinational logic sits between the flop and the CDC path.
- o_waddr = wbin[ADDR_SIZE-1:0]. It addresses the current write, so the RAM write at cycle N uses the pre-increment address.
- Full flag:
  - full_next = (wgray_next == {~i_wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], i_wq2_rptr[ADDR_SIZE-2:0]}); o_wfull <= full_next.
  - o_wfull asserts on the edge that accepts the filling write, so it is visible the cycle after the last write.
  - Full is pessimistic: deassertion lags a read by the 2-FF latency plus 1 cycle.
- Level and almost-full:
  - rbin = gray-to-binary of i_wq2_rptr (sub-module).
  - o_wlevel <= (wbin_next - rbin) modulo 2**(ADDR_SIZE+1).
  - o_walmost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- Overflow: set when i_winc && o_wfull; cleared by i_clr_ovf. If set and clear occur in the same cycle, set wins.
- Wrap-around: wbin 2**(ADDR_SIZE+1)-1 -> 0; Gray wraps 10..0 -> 00..0. Exactly one bit of o_wptr changes per accepted write, including at wrap.
- No state machine beyond the pointer counter; all outputs except o_waddr and o_wen are registered.

Decomposition:
- Shared package fifo_pkg, holding:
  - default ADDR_SIZE localparam;
  - pointer type: logic [ADDR_SIZE:0];
  - functions bin2gray and gray2bin, also used by the future read-side rptr_empty_gen.
- One sub-module gray2bin_conv, parameterized width, purely combinational XOR prefix, instantiated for i_wq2_rptr.

Test Plan:
- Reset check: assert rst for 2 cycles while driving i_winc=1 -> all outputs 0, o_waddr=0.
- Fill to full:
  - Stimulus: i_wq2_rptr=0, 16 consecutive writes.
  - Required: o_waddr steps 0..15; o_walmost_full=1 after the 12th write; o_wfull=1 after the 16th; o_wptr=5'b11000; o_wlevel=16.
- Overflow:
  - Write while full -> o_wen=0, o_wptr holds 5'b11000, o_overflow=1.
  - i_clr_ovf with i_winc=0 -> o_overflow=0 next cycle.
  - i_clr_ovf and i_winc together while full -> o_overflow stays 1.
- Release:
  - From full, drive i_wq2_rptr=5'b00001 (gray 1) -> o_wfull=0 and o_wlevel=15 the next cycle.
  - A write is then accepted with o_waddr=0.
- Wrap:
  - Stimulus: 31 writes, with i_wq2_rptr tracking so the FIFO never fills.
  - Required: o_wptr=5'b10000 at wbin=31; the next write gives 5'b00000 with a single-bit change; o_waddr=0.
- Mid-op reset: at wbin=7, pulse rst for 1 cycle -> next edge o_wptr=0, o_wlevel=0, o_wfull=0, o_overflow=0.
